benes_switch_sequencer: RTL and testbench
=========================================

Name: benes_switch_sequencer

Overview:
- Upstream control stage for the packed RAM/module Benes interconnect.
- Holds a small table of precomputed switch settings: one entry per route pattern, with module-select and slot-select bits for every stage and switch.
- Plays a programmed run of entries to the interconnect's select inputs, each entry held for a programmable number of cycles.
- Emits a data-valid tag delayed to line up with the interconnect's data latency.

Parameters:
- SWITCH_NUM, 16, switches per stage
- STAGE_NUM, 9, Benes stages (2*log2(ports)-1)
- CFG_DEPTH, 16, table entries (power of 2)
- CFG_AW, $clog2(CFG_DEPTH), table address width
- HOLD_W, 8, hold-count width
- INTC_LATENCY, 12, cycles from select-valid to interconnect output-valid (>=1)

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- I_CFG_WE  in  1  table write strobe
- I_CFG_ADDR  in  CFG_AW  table write address
- I_CFG_MODULE_SEL  in  STAGE_NUM*SWITCH_NUM  module-direction select bits for the entry
- I_CFG_SLOT_SEL  in  STAGE_NUM*SWITCH_NUM  slot-direction select bits for the entry
- I_START  in  1  start-run pulse
- I_BASE_ADDR  in  CFG_AW  first entry of the run
- I_COUNT  in  CFG_AW+1  number of entries in the run (0..CFG_DEPTH)
- I_HOLD  in  HOLD_W  cycles each entry is held; 0 is treated as 1
- O_BUSY  out  1  run in progress (RUN or DRAIN)
- O_DONE  out  1  one-cycle completion pulse
- O_MODULE_SELECT  out  STAGE_NUM*SWITCH_NUM  to the interconnect module select
- O_SLOT_SELECT  out  STAGE_NUM*SWITCH_NUM  to the interconnect slot select
- O_CFG_VALID  out  1  select outputs carry an entry of the active run
- O_CFG_INDEX  out  CFG_AW  table address currently driven
- O_DATA_VALID  out  1  O_CFG_VALID delayed INTC_LATENCY cycles
- O_PARITY_ERR  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset: all outputs 0; FSM IDLE; delay line cleared; table contents not reset.
- Table writes:
  - Registered write at the next edge.
  - Accepted in any state.
  - Read-before-write: same-cycle read and write of one address returns the old data.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - I_START with I_COUNT=0: O_DONE pulses on the following cycle; stay IDLE; O_BUSY stays 0.
  - I_START with I_COUNT!=0: latch base, count and hold; go to RUN; O_BUSY=1 from the next cycle.
- RUN timing:
  - Start sampled at edge t; entry base appears on the select outputs at edge t+2 with O_CFG_VALID=1.
  - Each entry is held for H = max(I_HOLD,1) cycles.
  - The next entry follows with no bubble (prefetch read); O_CFG_INDEX tracks the driven address.
  - Address increments modulo CFG_DEPTH, so it wraps from CFG_DEPTH-1 to 0.
- Leaving RUN:
  - After the last entry's H cycles: O_CFG_VALID=0, go to DRAIN.
  - O_MODULE_SELECT, O_SLOT_SELECT and O_CFG_INDEX keep their last values.
- DRAIN:
  - Wait INTC_LATENCY cycles, so O_DATA_VALID fully de-asserts.
  - Then pulse O_DONE for 1 cycle with O_BUSY=0 in that same cycle; go to IDLE.
- I_START while O_BUSY=1: ignored.
- Hold parameters are latched at start; later changes have no effect on the active run.
- O_DATA_VALID: a shift register of depth INTC_LATENCY fed by O_CFG_VALID; runs in all states.
- Mid-operation reset: immediately forces IDLE, all outputs 0, delay line cleared; no O_DONE.
- Full-table run (I_COUNT=CFG_DEPTH, nonzero base): every entry is played exactly once, in wrapped order.

Optional Feature:
- Macro: BENES_CFG_PARITY_EN.
- Enabled:
  - Each table entry stores an even-parity bit over the module and slot bits, computed at write.
  - The bit is rechecked when the entry is driven.
  - A mismatch sets O_PARITY_ERR, which is sticky until reset.
  - Selects are still driven.
- Disabled: no parity storage; O_PARITY_ERR tied 0.

Test Plan:
- Reset release, no activity -> all outputs 0 and O_BUSY=0 for 20 cycles.
- Write entries 0..3 with distinct patterns; start base=0, count=4, hold=3 -> each pattern is held for exactly 3 cycles, starting 2 cycles after start, with no gaps.
- Start with O_DATA_VALID timing checked -> O_DATA_VALID rises exactly INTC_LATENCY cycles after O_CFG_VALID and lasts 12 cycles; O_DONE arrives INTC_LATENCY cycles after O_CFG_VALID falls.
- Start base=14, count=4, hold=0 -> indices 14,15,0,1, one cycle each; then a second I_START pulse during the run is ignored.
- Start with count=0 -> O_DONE pulse one cycle later, O_BUSY never asserted. Separately, assert reset at the middle of a run -> outputs 0 at once, and a new run after reset behaves normally.
- With BENES_CFG_PARITY_EN: back-door flip one stored bit of entry 2, then run over it -> O_PARITY_ERR rises when entry 2 is driven and stays high until reset.

Source files
------------

// File: rtl/benes_switch_sequencer.sv
// benes_switch_sequencer
// Control stage in front of the packed RAM/module Benes interconnect. A small
// table holds precomputed module/slot select words, one entry per route
// pattern. A run plays a contiguous (wrapping) range of entries onto the
// interconnect select inputs. Each entry is held for a programmable number of
// cycles. A data-valid tag is delayed to match the interconnect's data latency.
//
// Optional build macro: BENES_CFG_PARITY_EN
//   When defined, every entry stores an even-parity bit. The bit is checked when
//   the entry is driven, and a mismatch sets the sticky O_PARITY_ERR output.
//   When undefined, O_PARITY_ERR is tied low.
//
// Start/busy semantics: I_START is a single-cycle request. It is sampled only
// while O_BUSY is low and is ignored otherwise. O_DONE pulses once per accepted
// start, and O_BUSY is already low in the O_DONE cycle.
module benes_switch_sequencer #(
  parameter int SWITCH_NUM   = 16,
  parameter int STAGE_NUM    = 9,
  parameter int CFG_DEPTH    = 16,
  parameter int CFG_AW       = $clog2(CFG_DEPTH),
  parameter int HOLD_W       = 8,
  parameter int INTC_LATENCY = 12
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            I_CFG_WE,
  input  logic [CFG_AW-1:0]               I_CFG_ADDR,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0] I_CFG_MODULE_SEL,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0] I_CFG_SLOT_SEL,
  input  logic                            I_START,
  input  logic [CFG_AW-1:0]               I_BASE_ADDR,
  input  logic [CFG_AW:0]                 I_COUNT,
  input  logic [HOLD_W-1:0]               I_HOLD,
  output logic                            O_BUSY,
  output logic                            O_DONE,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] O_MODULE_SELECT,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] O_SLOT_SELECT,
  output logic                            O_CFG_VALID,
  output logic [CFG_AW-1:0]               O_CFG_INDEX,
  output logic                            O_DATA_VALID,
  output logic                            O_PARITY_ERR
);

  localparam int SEL_W   = STAGE_NUM * SWITCH_NUM;
  localparam int DRAIN_W = $clog2(INTC_LATENCY + 1);

  localparam logic [CFG_AW-1:0]  ADDR_ONE   = 1;
  localparam logic [CFG_AW:0]    CNT_ZERO   = '0;
  localparam logic [CFG_AW:0]    CNT_ONE    = 1;
  localparam logic [HOLD_W-1:0]  HOLD_ZERO  = '0;
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = 1;
  localparam logic [DRAIN_W-1:0] DRAIN_ZERO = '0;
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(INTC_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, next_state;

  // Switch-setting table (not reset)
  logic [SEL_W-1:0] mod_mem  [CFG_DEPTH];
  logic [SEL_W-1:0] slot_mem [CFG_DEPTH];

  // Run bookkeeping
  logic [CFG_AW-1:0]  fetch_addr;
  logic [CFG_AW:0]    fetch_left;
  logic [HOLD_W-1:0]  hold_q;

  // Prefetch stage: the next entry, read ahead so entries follow without a bubble
  logic               pf_valid;
  logic [SEL_W-1:0]   pf_mod;
  logic [SEL_W-1:0]   pf_slot;
  logic [CFG_AW-1:0]  pf_idx;

  // Output stage
  logic               out_valid;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SEL_W-1:0]   out_mod;
  logic [SEL_W-1:0]   out_slot;
  logic [CFG_AW-1:0]  out_idx;

  logic [DRAIN_W-1:0]     drain_cnt;
  logic                   done_q;
  logic [INTC_LATENCY-1:0] dv_sr;

  logic start_go;
  logic start_empty;
  logic consume;
  logic fetch_en;
  logic run_end;
  logic drain_end;
  logic busy_c;
  logic done_set;

  assign start_go    = (state == S_IDLE) && I_START && (I_COUNT != CNT_ZERO);
  assign start_empty = (state == S_IDLE) && I_START && (I_COUNT == CNT_ZERO);
  // Move the prefetched entry to the outputs when nothing is shown yet or the current hold expires
  assign consume     = (state == S_RUN) && pf_valid && (!out_valid || (hold_cnt == HOLD_ZERO));
  assign fetch_en    = (state == S_RUN) && (fetch_left != CNT_ZERO) && (!pf_valid || consume);
  assign run_end     = (state == S_RUN) && out_valid && (hold_cnt == HOLD_ZERO) && !pf_valid;
  assign drain_end   = (state == S_DRAIN) && (drain_cnt == DRAIN_ZERO);

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_go)  next_state = S_RUN;
      S_RUN:   if (run_end)   next_state = S_DRAIN;
      S_DRAIN: if (drain_end) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs: busy level and the request to pulse done next cycle
  always_comb begin
    busy_c   = (state != S_IDLE);
    done_set = start_empty || drain_end;
  end

  // Table write port; read-before-write falls out of the registered prefetch read
  always_ff @(posedge CLK) begin
    if (I_CFG_WE) begin
      mod_mem[I_CFG_ADDR]  <= I_CFG_MODULE_SEL;
      slot_mem[I_CFG_ADDR] <= I_CFG_SLOT_SEL;
    end
  end

  // Run parameters, prefetch stage and output stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_addr <= '0;
      fetch_left <= '0;
      hold_q     <= '0;
      pf_valid   <= 1'b0;
      pf_mod     <= '0;
      pf_slot    <= '0;
      pf_idx     <= '0;
      out_valid  <= 1'b0;
      hold_cnt   <= '0;
      out_mod    <= '0;
      out_slot   <= '0;
      out_idx    <= '0;
      drain_cnt  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_set;

      if (start_go) begin
        fetch_addr <= I_BASE_ADDR;
        fetch_left <= I_COUNT;
        hold_q     <= (I_HOLD == HOLD_ZERO) ? HOLD_ONE : I_HOLD;
      end else if (fetch_en) begin
        fetch_addr <= fetch_addr + ADDR_ONE;
        fetch_left <= fetch_left - CNT_ONE;
      end

      if (fetch_en) begin
        pf_mod   <= mod_mem[fetch_addr];
        pf_slot  <= slot_mem[fetch_addr];
        pf_idx   <= fetch_addr;
        pf_valid <= 1'b1;
      end else if (consume) begin
        pf_valid <= 1'b0;
      end

      if (consume) begin
        out_mod   <= pf_mod;
        out_slot  <= pf_slot;
        out_idx   <= pf_idx;
        out_valid <= 1'b1;
        hold_cnt  <= hold_q - HOLD_ONE;
      end else if (run_end) begin
        out_valid <= 1'b0;
      end else if (out_valid && (hold_cnt != HOLD_ZERO)) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end

      if (run_end) begin
        drain_cnt <= DRAIN_INIT;
      end else if ((state == S_DRAIN) && (drain_cnt != DRAIN_ZERO)) begin
        drain_cnt <= drain_cnt - DRAIN_ONE;
      end
    end
  end

  // Data-valid delay line, shifting in every state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dv_sr <= '0;
    end else begin
      dv_sr[0] <= out_valid;
      for (int i = 1; i < INTC_LATENCY; i++) begin
        dv_sr[i] <= dv_sr[i-1];
      end
    end
  end

`ifdef BENES_CFG_PARITY_EN
  logic par_mem [CFG_DEPTH];
  logic pf_par;
  logic perr_q;

  // Parity bit stored alongside each entry, computed from the written data
  always_ff @(posedge CLK) begin
    if (I_CFG_WE) par_mem[I_CFG_ADDR] <= ^{I_CFG_MODULE_SEL, I_CFG_SLOT_SEL};
  end

  // Carry parity through the prefetch stage and raise a sticky error when a bad entry is driven
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pf_par <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (fetch_en) pf_par <= par_mem[fetch_addr];
      if (consume && (^{pf_mod, pf_slot, pf_par})) perr_q <= 1'b1;
    end
  end

  assign O_PARITY_ERR = perr_q;
`else
  assign O_PARITY_ERR = 1'b0;
`endif

  assign O_BUSY          = busy_c;
  assign O_DONE          = done_q;
  assign O_MODULE_SELECT = out_mod;
  assign O_SLOT_SELECT   = out_slot;
  assign O_CFG_VALID     = out_valid;
  assign O_CFG_INDEX     = out_idx;
  assign O_DATA_VALID    = dv_sr[INTC_LATENCY-1];

endmodule

// File: tb/tb_benes_switch_sequencer.sv
// Testbench for benes_switch_sequencer. Expected outputs come from a cycle-offset
// model of a run: after a start sampled at edge t, the entries are shown from t+2
// for count*hold cycles, then data-valid trails by the latency, and done follows.
module tb_benes_switch_sequencer;

  localparam int SEL_W = 144;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int L     = 12;

  // Clock / reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic             I_CFG_WE;
  logic [AW-1:0]    I_CFG_ADDR;
  logic [SEL_W-1:0] I_CFG_MODULE_SEL;
  logic [SEL_W-1:0] I_CFG_SLOT_SEL;
  logic             I_START;
  logic [AW-1:0]    I_BASE_ADDR;
  logic [AW:0]      I_COUNT;
  logic [7:0]       I_HOLD;
  logic             O_BUSY;
  logic             O_DONE;
  logic [SEL_W-1:0] O_MODULE_SELECT;
  logic [SEL_W-1:0] O_SLOT_SELECT;
  logic             O_CFG_VALID;
  logic [AW-1:0]    O_CFG_INDEX;
  logic             O_DATA_VALID;
  logic             O_PARITY_ERR;

  benes_switch_sequencer dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .I_CFG_WE         (I_CFG_WE),
    .I_CFG_ADDR       (I_CFG_ADDR),
    .I_CFG_MODULE_SEL (I_CFG_MODULE_SEL),
    .I_CFG_SLOT_SEL   (I_CFG_SLOT_SEL),
    .I_START          (I_START),
    .I_BASE_ADDR      (I_BASE_ADDR),
    .I_COUNT          (I_COUNT),
    .I_HOLD           (I_HOLD),
    .O_BUSY           (O_BUSY),
    .O_DONE           (O_DONE),
    .O_MODULE_SELECT  (O_MODULE_SELECT),
    .O_SLOT_SELECT    (O_SLOT_SELECT),
    .O_CFG_VALID      (O_CFG_VALID),
    .O_CFG_INDEX      (O_CFG_INDEX),
    .O_DATA_VALID     (O_DATA_VALID),
    .O_PARITY_ERR     (O_PARITY_ERR)
  );

  // Reference model state
  logic [SEL_W-1:0] tbl_mod  [DEPTH];
  logic [SEL_W-1:0] tbl_slot [DEPTH];
  bit               bad      [DEPTH];
  logic [SEL_W-1:0] prev_mod;
  logic [SEL_W-1:0] prev_slot;
  logic [AW-1:0]    prev_idx;
  bit               perr_st;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [SEL_W-1:0] rand_sel();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[SEL_W-1:0];
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [2*SEL_W-1:0] obs, input logic [2*SEL_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit e_busy, input bit e_done, input bit e_cv,
                               input bit e_dv, input bit e_perr, input logic [AW-1:0] e_idx,
                               input logic [SEL_W-1:0] e_mod, input logic [SEL_W-1:0] e_slot);
    check({tag, ".ctrl"},
          {279'd0, O_BUSY, O_DONE, O_CFG_VALID, O_DATA_VALID, O_PARITY_ERR, O_CFG_INDEX},
          {279'd0, e_busy, e_done, e_cv, e_dv, e_perr, e_idx});
    check({tag, ".sel"}, {O_MODULE_SELECT, O_SLOT_SELECT}, {e_mod, e_slot});
  endtask

  // Driver: one table write, reflected in the model
  task automatic write_entry(input logic [AW-1:0] a, input logic [SEL_W-1:0] m, input logic [SEL_W-1:0] s);
    @(negedge CLK);
    I_CFG_WE = 1'b1;
    I_CFG_ADDR = a;
    I_CFG_MODULE_SEL = m;
    I_CFG_SLOT_SEL = s;
    @(posedge CLK);
    #1;
    I_CFG_WE = 1'b0;
    tbl_mod[a] = m;
    tbl_slot[a] = s;
    bad[a] = 1'b0;
  endtask

  // Driver + model: one run, checked every cycle; poke_at re-pulses start mid-run with other values
  task automatic run_check(input string tag, input logic [AW-1:0] base, input logic [AW:0] cnt,
                           input logic [7:0] hold, input int poke_at);
    int hh, on, c_end, k;
    logic [AW-1:0] e_idx;
    logic [SEL_W-1:0] e_mod, e_slot;
    bit e_cv, e_dv, e_done, e_busy;
    hh = (hold == 8'd0) ? 1 : int'(hold);
    on = int'(cnt) * hh;
    @(negedge CLK);
    I_START = 1'b1;
    I_BASE_ADDR = base;
    I_COUNT = cnt;
    I_HOLD = hold;
    @(posedge CLK);
    #1;
    if (cnt == 5'd0) begin
      check_outputs({tag, ".empty_done"}, 1'b0, 1'b1, 1'b0, 1'b0, perr_st, prev_idx, prev_mod, prev_slot);
      @(negedge CLK);
      I_START = 1'b0;
      @(posedge CLK);
      #1;
      check_outputs({tag, ".empty_after"}, 1'b0, 1'b0, 1'b0, 1'b0, perr_st, prev_idx, prev_mod, prev_slot);
      return;
    end
    c_end = 2 + on + L + 1;
    for (int c = 0; c <= c_end; c++) begin
      if (c > 0) begin
        @(negedge CLK);
        I_START = (c == poke_at);
        if (c == poke_at) begin
          I_BASE_ADDR = 4'($urandom_range(0, 15));
          I_COUNT = 5'($urandom_range(1, 16));
          I_HOLD = 8'($urandom_range(0, 9));
        end
        @(posedge CLK);
        #1;
      end
      e_cv   = (c >= 2) && (c < 2 + on);
      e_dv   = (c >= 2 + L) && (c < 2 + on + L);
      e_done = (c == 2 + on + L);
      e_busy = (c < 2 + on + L);
      if (c >= 2) begin
        k = e_cv ? (c - 2) / hh : int'(cnt) - 1;
        e_idx = 4'((int'(base) + k) % DEPTH);
        e_mod = tbl_mod[e_idx];
        e_slot = tbl_slot[e_idx];
      end else begin
        e_idx = prev_idx;
        e_mod = prev_mod;
        e_slot = prev_slot;
      end
      if (e_cv && bad[e_idx]) perr_st = 1'b1;
      check_outputs($sformatf("%s.c%0d", tag, c), e_busy, e_done, e_cv, e_dv, perr_st, e_idx, e_mod, e_slot);
    end
    I_START = 1'b0;
    prev_idx = 4'((int'(base) + int'(cnt) - 1) % DEPTH);
    prev_mod = tbl_mod[prev_idx];
    prev_slot = tbl_slot[prev_idx];
  endtask

  task automatic model_reset();
    prev_mod = '0;
    prev_slot = '0;
    prev_idx = '0;
    perr_st = 1'b0;
  endtask

  // Directed sequence with randomized table contents and run parameters
  initial begin
    I_CFG_WE = 1'b0;
    I_CFG_ADDR = '0;
    I_CFG_MODULE_SEL = '0;
    I_CFG_SLOT_SEL = '0;
    I_START = 1'b0;
    I_BASE_ADDR = '0;
    I_COUNT = '0;
    I_HOLD = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tbl_mod[i] = '0;
      tbl_slot[i] = '0;
      bad[i] = 1'b0;
    end
    model_reset();

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      check_outputs($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    end

    for (int i = 0; i < DEPTH; i++) write_entry(4'(i), rand_sel(), rand_sel());

    run_check("base0_hold3", 4'd0, 5'd4, 8'd3, -1);
    run_check("wrap_hold0", 4'd14, 5'd4, 8'd0, 3);
    run_check("count0", 4'd7, 5'd0, 8'd5, -1);
    run_check("full_table", 4'd5, 5'd16, 8'd1, 6);

    for (int r = 0; r < 4; r++) begin
      run_check($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)),
                8'($urandom_range(0, 3)), int'($urandom_range(3, 10)));
    end

    // Reset in the middle of a run
    @(negedge CLK);
    I_START = 1'b1;
    I_BASE_ADDR = 4'd2;
    I_COUNT = 5'd6;
    I_HOLD = 8'd2;
    @(negedge CLK);
    I_START = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge CLK);
    #1;
    check_outputs("midreset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_check("after_reset", 4'd3, 5'd3, 8'd2, -1);

`ifdef BENES_CFG_PARITY_EN
    // Corrupt one stored bit of entry 2 behind the table's back
    @(negedge CLK);
    dut.mod_mem[2][7] = ~dut.mod_mem[2][7];
    tbl_mod[2][7] = ~tbl_mod[2][7];
    bad[2] = 1'b1;
    run_check("parity", 4'd0, 5'd4, 8'd2, -1);
    repeat (3) @(posedge CLK);
    #1;
    check_outputs("parity_sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, prev_idx, prev_mod, prev_slot);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs("parity_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge CLK);
    RST_N = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
